// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX observation inputs and stall/flush/bubble controls.
// The datapath side is the master; the hazard controller is the slave.
interface hazard_ctrl_if;
  logic        mem_read_ex;
  logic [4:0]  rt_ex;
  logic [4:0]  rs_id;
  logic [4:0]  rt_id;
  logic        muldiv_start_ex;
  logic        muldiv_op_id;
  logic        hilo_use_id;
  logic        branch_taken_id;
  logic        jump_id;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [15:0] stall_cnt;

  modport master (
    output mem_read_ex, rt_ex, rs_id, rt_id, muldiv_start_ex, muldiv_op_id,
           hilo_use_id, branch_taken_id, jump_id,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy,
           muldiv_done, stall_cnt
  );

  modport slave (
    input  mem_read_ex, rt_ex, rs_id, rt_id, muldiv_start_ex, muldiv_op_id,
           hilo_use_id, branch_taken_id, jump_id,
    output pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy,
           muldiv_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use and HI/LO stalls, branch flush,
// mult/div busy sequencer and saturating stall-cycle counter.
//
// state | meaning
// IDLE  | busy_cnt == 0, no mult/div in flight
// BUSY  | busy_cnt != 0, counting down until HI/LO are valid
module hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = 6
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(MULDIV_CYCLES);
  localparam logic [CNT_W-1:0] BUSY_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic             done_q, done_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             busy;
  logic             load_use;
  logic             md_hazard;
  logic             stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_q  <= '0;
      done_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      done_q      <= done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign busy      = (busy_cnt_q != '0);
  assign load_use  = hz.mem_read_ex & (hz.rt_ex != 5'd0) &
                     ((hz.rt_ex == hz.rs_id) | (hz.rt_ex == hz.rt_id));
  assign md_hazard = (busy | hz.muldiv_start_ex) & (hz.hilo_use_id | hz.muldiv_op_id);
  assign stall     = load_use | md_hazard;

  // A start while BUSY reloads the counter and drops the pending Done.
  always_comb begin
    busy_cnt_d  = busy_cnt_q;
    done_d      = 1'b0;
    stall_cnt_d = stall_cnt_q;
    if (hz.muldiv_start_ex) begin
      busy_cnt_d = BUSY_LOAD;
    end else if (busy) begin
      busy_cnt_d = busy_cnt_q - BUSY_ONE;
      done_d     = (busy_cnt_q == BUSY_ONE);
    end
    if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // Stall wins over flush: branch operands may still be in flight.
  always_comb begin
    hz.pc_write    = ~stall;
    hz.ifid_write  = ~stall;
    hz.ifid_flush  = (hz.branch_taken_id | hz.jump_id) & ~stall;
    hz.idex_bubble = stall;
    hz.muldiv_busy = busy;
    hz.muldiv_done = done_q;
    hz.stall_cnt   = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed and random stimulus against a
// cycle-indexed reference model; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int N = 4;

  typedef struct {
    logic        pcw;
    logic        ifw;
    logic        flush;
    logic        bub;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  hazard_ctrl_if hz();

  hazard_ctrl #(.MULDIV_CYCLES(N), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   exp_q[$];

  // model: absolute cycle index, cycle in which Done is due, stalled-cycle tally
  longint cyc      = 0;
  longint done_cyc = -1;
  int     stalls   = 0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  task automatic set_inputs(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                            input logic [4:0] rti, input logic st, input logic mdop,
                            input logic hilo, input logic br, input logic jp);
    hz.mem_read_ex     = mr;
    hz.rt_ex           = rte;
    hz.rs_id           = rsi;
    hz.rt_id           = rti;
    hz.muldiv_start_ex = st;
    hz.muldiv_op_id    = mdop;
    hz.hilo_use_id     = hilo;
    hz.branch_taken_id = br;
    hz.jump_id         = jp;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                       input logic [4:0] rti, input logic st, input logic mdop,
                       input logic hilo, input logic br, input logic jp);
    exp_t e;
    bit   busy, lu, mh, s;
    @(posedge clk);
    #1;
    set_inputs(mr, rte, rsi, rti, st, mdop, hilo, br, jp);
    busy    = (cyc < done_cyc);
    lu      = mr && (rte != 0) && ((rte == rsi) || (rte == rti));
    mh      = (busy || st) && (hilo || mdop);
    s       = lu || mh;
    e.pcw   = !s;
    e.ifw   = !s;
    e.flush = (br || jp) && !s;
    e.bub   = s;
    e.busy  = busy;
    e.done  = (cyc == done_cyc);
    e.cnt   = (stalls > 65535) ? 16'hFFFF : 16'(stalls);
    exp_q.push_back(e);
    if (s) stalls++;
    if (st) done_cyc = cyc + N + 1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle, outputs checked before any clock edge.
  task automatic reset_mid;
    @(posedge clk);
    #3;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("rst_busy",   16'(hz.muldiv_busy), 16'd0);
    chk("rst_done",   16'(hz.muldiv_done), 16'd0);
    chk("rst_cnt",    hz.stall_cnt,        16'd0);
    chk("rst_pcw",    16'(hz.pc_write),    16'd1);
    chk("rst_ifw",    16'(hz.ifid_write),  16'd1);
    chk("rst_flush",  16'(hz.ifid_flush),  16'd0);
    chk("rst_bubble", 16'(hz.idex_bubble), 16'd0);
    @(posedge clk);
    #2;
    rst      = 1'b0;
    stalls   = 0;
    done_cyc = -1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_write",    16'(hz.pc_write),    16'(e.pcw));
        chk("ifid_write",  16'(hz.ifid_write),  16'(e.ifw));
        chk("ifid_flush",  16'(hz.ifid_flush),  16'(e.flush));
        chk("idex_bubble", 16'(hz.idex_bubble), 16'(e.bub));
        chk("muldiv_busy", 16'(hz.muldiv_busy), 16'(e.busy));
        chk("muldiv_done", 16'(hz.muldiv_done), 16'(e.done));
        chk("stall_cnt",   hz.stall_cnt,        e.cnt);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("init_busy",  16'(hz.muldiv_busy), 16'd0);
    chk("init_cnt",   hz.stall_cnt,        16'd0);
    chk("init_pcw",   16'(hz.pc_write),    16'd1);
    chk("init_flush", 16'(hz.ifid_flush),  16'd0);
    #14;
    rst = 1'b0;
    idle(2);

    // load-use on rs, then bubble in EX; then Rt_EX == 0 never stalls
    drive(1, 8, 8, 3, 0, 0, 0, 0, 0);
    idle(1);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 9, 2, 9, 0, 0, 0, 0, 0);
    idle(1);

    // mult then dependent mfhi held in ID
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < N + 2; i++) drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(1);

    // back-to-back mult: second waits in ID, then issues
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < N + 1; i++) drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(N + 3);

    // branch / jump under load-use stall, then released
    drive(1, 5, 5, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 6, 0, 6, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);

    // load-use and md_hazard together count once
    drive(1, 7, 7, 0, 1, 1, 0, 0, 0);
    idle(N + 2);

    // restart while busy, including at the last busy cycle
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(N - 1);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(N + 3);

    for (int i = 0; i < 1500; i++)
      drive(($urandom % 3) == 0, 5'($urandom % 4), 5'($urandom % 4), 5'($urandom % 4),
            ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
            ($urandom % 4) == 0, ($urandom % 6) == 0);

    // reset while busy: no Done afterwards
    idle(N + 2);
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    reset_mid();
    idle(N + 4);

    // saturation of the stall counter
    for (int i = 0; i < 65540; i++) drive(1, 4, 4, 0, 0, 0, 0, 0, 0);
    idle(3);

    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS datapath. It watches the ID stage and the ID/EX pipeline register outputs. It generates PC/IF-ID write enables, the IF/ID flush, and the ID/EX bubble (control-field zeroing). It owns a multi-cycle multiply/divide busy sequencer that stalls dependent HI/LO instructions, and it keeps a saturating stall-cycle performance counter.

## Interface
- MULDIV_CYCLES, 32, cycles from mult/div issue in EX until HI/LO valid (2..2^CNT_W-1)
- CNT_W, 6, width of busy counter
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  asynchronous, active-high reset
- MemRead_EX  in  1  MEM_EX read bit of instruction currently in EX
- Rt_EX  in  5  Rt field of instruction in EX
- Rs_ID  in  5  Rs field of instruction in ID
- Rt_ID  in  5  Rt field of instruction in ID
- MulDiv_Start_EX  in  1  mult/multu/div/divu occupying EX this cycle
- MulDiv_Op_ID  in  1  instruction in ID is mult/multu/div/divu
- HiLo_Use_ID  in  1  instruction in ID is mfhi/mflo
- Branch_Taken_ID  in  1  branch resolved taken in ID
- Jump_ID  in  1  j/jal/jr in ID
- PCWrite  out  1  PC load enable
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush  out  1  zero IF/ID instruction (squash fetched slot)
- IDEX_Bubble  out  1  force WB/MEM/EX control fields into ID/EX to 0
- MulDiv_Busy  out  1  busy counter nonzero
- MulDiv_Done  out  1  one-cycle pulse when HI/LO become valid
- Stall_Cnt  out  16  saturating count of stalled cycles

## Operation
- Busy sequencer (FSM IDLE/BUSY, held in busy_cnt):
  - IDLE (busy_cnt==0): MulDiv_Start_EX loads busy_cnt <= MULDIV_CYCLES and moves to BUSY.
  - BUSY: busy_cnt decrements by 1 per cycle. At the 1->0 transition, MulDiv_Done=1 for exactly that next cycle and the FSM returns to IDLE.
  - MulDiv_Start_EX while BUSY cannot occur, because the structural stall below prevents it. If it does occur, the counter reloads MULDIV_CYCLES and no Done pulse is issued for the aborted operation.
- MulDiv_Busy = (busy_cnt != 0). It is registered, not a function of the inputs.
- load_use = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID)).
- md_hazard = (MulDiv_Busy | MulDiv_Start_EX) & (HiLo_Use_ID | MulDiv_Op_ID).
- stall = load_use | md_hazard.
- PCWrite = IFID_Write = ~stall; IDEX_Bubble = stall.
- IFID_Flush = (Branch_Taken_ID | Jump_ID) & ~stall. The stall takes priority because branch operands in ID may still be pending. The branch re-evaluates after the stall releases.
- Stall_Cnt increments by 1 on each edge where stall==1. It holds at 16'hFFFF.
- All outputs except MulDiv_Busy, MulDiv_Done and Stall_Cnt are combinational from the current inputs and busy_cnt.

## Timing
- Reset values: busy_cnt=0 (IDLE), MulDiv_Busy=0, MulDiv_Done=0, Stall_Cnt=0.
- With all inputs 0 during reset: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- Rst asserted mid-operation clears busy_cnt and Stall_Cnt immediately (asynchronously). No Done pulse follows.
- Load-use stall: exactly 1 cycle. The bubble enters EX next cycle, so MemRead_EX drops and the stall releases.
- Mult/div issued at edge k into EX (Start_EX=1 in cycle k): busy_cnt=MULDIV_CYCLES after edge k+1 and reaches 0 after edge k+1+MULDIV_CYCLES. Done is high in that cycle.
- A dependent mfhi in ID stalls from cycle k through the last BUSY cycle and proceeds in the Done cycle.
- Load-use and md_hazard in the same cycle produce a single stall. Stall_Cnt increments once.
- Branch or jump with no stall: flush is asserted in the same cycle. PCWrite stays 1 so the target is loaded.

## Test plan
- Reset: Rst=1 pulse mid-cycle -> MulDiv_Busy=0, Stall_Cnt=0, PCWrite=1, IDEX_Bubble=0 without waiting for a clock edge.
- Load-use: MemRead_EX=1, Rt_EX=8, Rs_ID=8 for one cycle, then bubble -> PCWrite=0, IDEX_Bubble=1 for 1 cycle, Stall_Cnt=1. Repeat with Rt_EX=0 -> no stall.
- Mult then mfhi (MULDIV_CYCLES=4): Start_EX=1 in cycle k with HiLo_Use_ID=1 held -> stall in cycles k..k+4, Done=1 and stall=0 in cycle k+5, Stall_Cnt=5.
- Back-to-back mult: MulDiv_Op_ID=1 while Busy -> stall until Done; the second Start_EX reloads to 4.
- Branch under stall: Branch_Taken_ID=1 with load_use=1 -> IFID_Flush=0, PCWrite=0. Next cycle load_use=0 -> IFID_Flush=1, PCWrite=1.
- Saturation: preload via 65 540 stalled cycles -> Stall_Cnt holds 16'hFFFF. Rst asserted in the BUSY state -> no Done pulse afterwards.
